// File: rtl/compare_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : compare_sequencer
// Description : Drives one comparison pass over a loaded bitmap: column
//               slices first, then top/bottom row-slice pairs, accumulating a
//               saturating ALU match score with a per-wait timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module compare_sequencer #(
    parameter int NCOLS     = 24,
    parameter int NROWPAIRS = 32,
    parameter int TIMEOUT   = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        nextcol,
    output logic        nextrowtop,
    output logic        nextrowbot,
    input  logic        colready,
    input  logic        rowtopready,
    input  logic        rowbotready,
    output logic        alu_go,
    output logic        alu_sel,
    input  logic        alu_done,
    input  logic [7:0]  alu_score,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [15:0] score,
    output logic [4:0]  col_idx,
    output logic [5:0]  row_idx
);

    // Internal counters may be wider than the index ports so large bitmaps still terminate.
    localparam int c_CW = ($clog2(NCOLS + 1) > 5) ? $clog2(NCOLS + 1) : 5;
    localparam int c_RW = ($clog2(NROWPAIRS + 1) > 6) ? $clog2(NROWPAIRS + 1) : 6;
    localparam logic [c_CW-1:0] c_COL_LAST = c_CW'(NCOLS);
    localparam logic [c_RW-1:0] c_ROW_LAST = c_RW'(NROWPAIRS);
    localparam logic [7:0]      c_TMO_LAST = 8'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_COL_REQ  = 3'd1,
        S_COL_WAIT = 3'd2,
        S_COL_ALU  = 3'd3,
        S_ROW_REQ  = 3'd4,
        S_ROW_WAIT = 3'd5,
        S_ROW_ALU  = 3'd6,
        S_DONE     = 3'd7
    } state_t;

    state_t          r_state, w_state_nxt;
    logic [15:0]     r_score, w_score_nxt;
    logic [c_CW-1:0] r_col_idx, w_col_nxt;
    logic [c_RW-1:0] r_row_idx, w_row_nxt;
    logic            r_top_got, w_top_nxt;
    logic            r_bot_got, w_bot_nxt;
    logic [7:0]      r_tmo, w_tmo_nxt;
    logic            w_err_nxt;
    logic            w_go_nxt;
    logic            w_sel_nxt;

    logic [16:0]     w_sum;
    logic [15:0]     w_score_sat;
    logic [c_CW-1:0] w_col_inc;
    logic [c_RW-1:0] w_row_inc;
    logic            w_top_seen;
    logic            w_bot_seen;
    logic            w_tmo_hit;

    assign w_sum       = {1'b0, r_score} + {9'd0, alu_score};
    assign w_score_sat = w_sum[16] ? 16'hFFFF : w_sum[15:0];
    assign w_col_inc   = r_col_idx + 1'b1;
    assign w_row_inc   = r_row_idx + 1'b1;
    assign w_top_seen  = r_top_got | rowtopready;
    assign w_bot_seen  = r_bot_got | rowbotready;
    assign w_tmo_hit   = (r_tmo == c_TMO_LAST);

    assign score   = r_score;
    assign col_idx = r_col_idx[4:0];
    assign row_idx = r_row_idx[5:0];

    always_comb begin
        w_state_nxt = r_state;
        w_score_nxt = r_score;
        w_col_nxt   = r_col_idx;
        w_row_nxt   = r_row_idx;
        w_top_nxt   = r_top_got;
        w_bot_nxt   = r_bot_got;
        w_tmo_nxt   = 8'd0;
        w_err_nxt   = error;
        w_go_nxt    = 1'b0;
        w_sel_nxt   = alu_sel;

        case (r_state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    w_state_nxt = S_COL_REQ;
                    w_score_nxt = 16'd0;
                    w_col_nxt   = '0;
                    w_row_nxt   = '0;
                    w_err_nxt   = 1'b0;
                end
            end
            S_COL_REQ: w_state_nxt = S_COL_WAIT;
            S_COL_WAIT: begin
                if (colready) begin
                    w_state_nxt = S_COL_ALU;
                    w_go_nxt    = 1'b1;
                    w_sel_nxt   = 1'b0;
                end else if (w_tmo_hit) begin
                    w_state_nxt = S_DONE;
                    w_err_nxt   = 1'b1;
                end else begin
                    w_tmo_nxt = r_tmo + 8'd1;
                end
            end
            S_COL_ALU: begin
                if (alu_done) begin
                    w_score_nxt = w_score_sat;
                    w_col_nxt   = w_col_inc;
                    w_state_nxt = (w_col_inc == c_COL_LAST) ? S_ROW_REQ : S_COL_REQ;
                end else if (w_tmo_hit) begin
                    w_state_nxt = S_DONE;
                    w_err_nxt   = 1'b1;
                end else begin
                    w_tmo_nxt = r_tmo + 8'd1;
                end
            end
            S_ROW_REQ: begin
                w_top_nxt   = 1'b0;
                w_bot_nxt   = 1'b0;
                w_state_nxt = S_ROW_WAIT;
            end
            S_ROW_WAIT: begin
                // Either half of the pair may arrive first; remember each until both are in.
                w_top_nxt = w_top_seen;
                w_bot_nxt = w_bot_seen;
                if (w_top_seen && w_bot_seen) begin
                    w_state_nxt = S_ROW_ALU;
                    w_go_nxt    = 1'b1;
                    w_sel_nxt   = 1'b1;
                end else if (w_tmo_hit) begin
                    w_state_nxt = S_DONE;
                    w_err_nxt   = 1'b1;
                end else begin
                    w_tmo_nxt = r_tmo + 8'd1;
                end
            end
            S_ROW_ALU: begin
                if (alu_done) begin
                    w_score_nxt = w_score_sat;
                    w_row_nxt   = w_row_inc;
                    w_state_nxt = (w_row_inc == c_ROW_LAST) ? S_DONE : S_ROW_REQ;
                end else if (w_tmo_hit) begin
                    w_state_nxt = S_DONE;
                    w_err_nxt   = 1'b1;
                end else begin
                    w_tmo_nxt = r_tmo + 8'd1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Status and strobe outputs are decoded from the next state so they are registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_score    <= 16'd0;
            r_col_idx  <= '0;
            r_row_idx  <= '0;
            r_top_got  <= 1'b0;
            r_bot_got  <= 1'b0;
            r_tmo      <= 8'd0;
            error      <= 1'b0;
            alu_go     <= 1'b0;
            alu_sel    <= 1'b0;
            nextcol    <= 1'b0;
            nextrowtop <= 1'b0;
            nextrowbot <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_score    <= w_score_nxt;
            r_col_idx  <= w_col_nxt;
            r_row_idx  <= w_row_nxt;
            r_top_got  <= w_top_nxt;
            r_bot_got  <= w_bot_nxt;
            r_tmo      <= w_tmo_nxt;
            error      <= w_err_nxt;
            alu_go     <= w_go_nxt;
            alu_sel    <= w_sel_nxt;
            nextcol    <= (w_state_nxt == S_COL_REQ);
            nextrowtop <= (w_state_nxt == S_ROW_REQ);
            nextrowbot <= (w_state_nxt == S_ROW_REQ);
            busy       <= (w_state_nxt != S_IDLE) && (w_state_nxt != S_DONE);
            done       <= (w_state_nxt == S_DONE);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_compare_sequencer.sv
`default_nettype none
// Directed bench for compare_sequencer: a cycle-stepped responder plays the
// slice sources and the ALU; a second instance with a large bitmap covers saturation.
module tb_compare_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       colready, rowtopready, rowbotready, alu_done;
    logic [7:0] alu_score;
    bit         use_big;

    logic s_nextcol, s_nrt, s_nrb, s_go, s_sel, s_busy, s_done, s_err;
    logic [15:0] s_score;
    logic [4:0]  s_col;
    logic [5:0]  s_row;
    logic b_nextcol, b_nrt, b_nrb, b_go, b_sel, b_busy, b_done, b_err;
    logic [15:0] b_score;
    logic [4:0]  b_col;
    logic [5:0]  b_row;

    logic m_nextcol, m_nrt, m_nrb, m_go, m_sel, m_busy, m_done, m_err;
    logic [15:0] m_score;
    logic [4:0]  m_col;
    logic [5:0]  m_row;

    int n_vec = 0;
    int n_err = 0;
    int n_col, n_row, n_go, n_viol, t_miss, cyc_end;

    always #5 clk = ~clk;

    compare_sequencer dut (
        .clk(clk), .rst(rst), .start(start & ~use_big),
        .nextcol(s_nextcol), .nextrowtop(s_nrt), .nextrowbot(s_nrb),
        .colready(colready), .rowtopready(rowtopready), .rowbotready(rowbotready),
        .alu_go(s_go), .alu_sel(s_sel), .alu_done(alu_done), .alu_score(alu_score),
        .busy(s_busy), .done(s_done), .error(s_err), .score(s_score),
        .col_idx(s_col), .row_idx(s_row)
    );

    compare_sequencer #(.NCOLS(200), .NROWPAIRS(100), .TIMEOUT(255)) dut_big (
        .clk(clk), .rst(rst), .start(start & use_big),
        .nextcol(b_nextcol), .nextrowtop(b_nrt), .nextrowbot(b_nrb),
        .colready(colready), .rowtopready(rowtopready), .rowbotready(rowbotready),
        .alu_go(b_go), .alu_sel(b_sel), .alu_done(alu_done), .alu_score(alu_score),
        .busy(b_busy), .done(b_done), .error(b_err), .score(b_score),
        .col_idx(b_col), .row_idx(b_row)
    );

    assign m_nextcol = use_big ? b_nextcol : s_nextcol;
    assign m_nrt     = use_big ? b_nrt     : s_nrt;
    assign m_nrb     = use_big ? b_nrb     : s_nrb;
    assign m_go      = use_big ? b_go      : s_go;
    assign m_sel     = use_big ? b_sel     : s_sel;
    assign m_busy    = use_big ? b_busy    : s_busy;
    assign m_done    = use_big ? b_done    : s_done;
    assign m_err     = use_big ? b_err     : s_err;
    assign m_score   = use_big ? b_score   : s_score;
    assign m_col     = use_big ? b_col     : s_col;
    assign m_row     = use_big ? b_row     : s_row;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        start       = 1'b0;
        colready    = 1'b0;
        rowtopready = 1'b0;
        rowbotready = 1'b0;
        alu_done    = 1'b0;
    endtask

    // Readies arrive dt/db cycles after the row request, colready and alu_done one cycle after.
    task automatic run_pass(input int dt, input int db, input int miss_col, input logic [7:0] sc,
                            input bit inj, input int abort_row, input int budget);
        int  col_cd, top_cd, bot_cd, alu_cd, cyc;
        bit  topf, botf;
        logic pnc, pnr, pgo;
        n_col = 0; n_row = 0; n_go = 0; n_viol = 0; t_miss = -1;
        col_cd = 0; top_cd = 0; bot_cd = 0; alu_cd = 0; cyc = 0;
        topf = 0; botf = 0; pnc = 0; pnr = 0; pgo = 0;
        clear_inputs();
        alu_score = sc;
        start = 1'b1;
        step();
        start = 1'b0;
        check("start_clears_score", {16'd0, m_score}, 32'd0);
        check("start_busy", {31'd0, m_busy}, 32'd1);
        while (!m_done && cyc < budget) begin
            clear_inputs();
            if (col_cd > 0) begin
                col_cd--;
                if (col_cd == 0) begin
                    colready = 1'b1;
                    if (inj && n_col == 6) start = 1'b1;
                end
            end
            if (top_cd > 0) begin
                top_cd--;
                if (top_cd == 0) begin rowtopready = 1'b1; topf = 1; end
            end
            if (bot_cd > 0) begin
                bot_cd--;
                if (bot_cd == 0) begin rowbotready = 1'b1; botf = 1; end
            end
            if (alu_cd > 0) begin
                alu_cd--;
                if (alu_cd == 0) alu_done = 1'b1;
            end
            if (m_nextcol) begin
                if (pnc) n_viol++;
                n_col++;
                if (n_col - 1 != miss_col) col_cd = 1;
                else t_miss = cyc;
            end
            if (m_nrt || m_nrb) begin
                if (!(m_nrt && m_nrb) || pnr) n_viol++;
                n_row++;
                if (n_row == abort_row) return;
                topf = 0; botf = 0; top_cd = dt; bot_cd = db;
            end
            if (m_go) begin
                if (pgo) n_viol++;
                n_go++;
                if (m_sel != (n_row > 0)) n_viol++;
                if (m_sel && !(topf && botf)) n_viol++;
                alu_cd = 1;
                if (inj && m_sel && n_row == 10) start = 1'b1;
            end
            pnc = m_nextcol; pnr = m_nrt | m_nrb; pgo = m_go;
            step();
            cyc++;
        end
        cyc_end = cyc;
        clear_inputs();
    endtask

    initial begin
        int cnt;
        use_big = 0;
        alu_score = 8'd0;
        clear_inputs();
        rst = 1'b1;
        repeat (3) step();
        check("rst_busy", {31'd0, m_busy}, 32'd0);
        check("rst_done", {31'd0, m_done}, 32'd0);
        check("rst_score", {16'd0, m_score}, 32'd0);
        check("rst_nextcol", {31'd0, m_nextcol}, 32'd0);
        @(negedge clk) rst = 1'b0;
        step();
        check("idle_idx", {21'd0, m_col, m_row}, 32'd0);
        check("idle_err_go", {30'd0, m_err, m_go}, 32'd0);

        // Immediate responder, simultaneous row readies
        run_pass(1, 1, -1, 8'd1, 0, -1, 2000);
        check("p1_done", {31'd0, m_done}, 32'd1);
        check("p1_busy", {31'd0, m_busy}, 32'd0);
        check("p1_err", {31'd0, m_err}, 32'd0);
        check("p1_score", {16'd0, m_score}, 32'd56);
        check("p1_col_idx", {27'd0, m_col}, 32'd24);
        check("p1_row_idx", {26'd0, m_row}, 32'd32);
        check("p1_nextcol_pulses", n_col, 32'd24);
        check("p1_row_pulses", n_row, 32'd32);
        check("p1_alu_go", n_go, 32'd56);
        check("p1_protocol", n_viol, 32'd0);

        // Top then bottom (bottom late), full-scale scores
        run_pass(1, 5, -1, 8'd255, 0, -1, 2000);
        check("p2_score", {16'd0, m_score}, 32'd14280);
        check("p2_alu_go", n_go, 32'd56);
        check("p2_protocol", n_viol, 32'd0);

        // Column 3 never answers
        run_pass(1, 1, 3, 8'd1, 0, -1, 2000);
        check("tmo_done", {31'd0, m_done}, 32'd1);
        check("tmo_err", {31'd0, m_err}, 32'd1);
        check("tmo_col_idx", {27'd0, m_col}, 32'd3);
        check("tmo_score", {16'd0, m_score}, 32'd3);
        check("tmo_nextcol", n_col, 32'd4);
        check("tmo_latency", cyc_end - t_miss, 32'd256);
        cnt = 0;
        repeat (20) begin
            colready = 1'b1;
            step();
            if (m_nextcol || m_go) cnt++;
        end
        colready = 1'b0;
        check("tmo_quiet", cnt, 32'd0);
        check("tmo_held", {31'd0, m_done}, 32'd1);

        // Bottom before top, start pulses while busy
        run_pass(5, 1, -1, 8'd2, 1, -1, 2000);
        check("p4_err_cleared", {31'd0, m_err}, 32'd0);
        check("p4_score", {16'd0, m_score}, 32'd112);
        check("p4_counts", {21'd0, m_col, m_row}, {21'd0, 5'd24, 6'd32});
        check("p4_nextcol", n_col, 32'd24);
        check("p4_alu_go", n_go, 32'd56);
        check("p4_protocol", n_viol, 32'd0);

        // Large bitmap saturates the accumulator
        use_big = 1;
        run_pass(1, 1, -1, 8'd255, 0, -1, 3000);
        check("big_done", {31'd0, m_done}, 32'd1);
        check("big_err", {31'd0, m_err}, 32'd0);
        check("big_score_sat", {16'd0, m_score}, 32'hFFFF);
        check("big_alu_go", n_go, 32'd300);
        check("big_idx_low_bits", {21'd0, m_col, m_row}, {21'd0, 5'd8, 6'd36});
        use_big = 0;

        // Asynchronous reset while waiting for a row pair
        run_pass(1, 1, -1, 8'd1, 0, 4, 2000);
        clear_inputs();
        step();
        check("pre_rst_busy", {31'd0, m_busy}, 32'd1);
        #2 rst = 1'b1;
        #1;
        check("arst_busy", {31'd0, m_busy}, 32'd0);
        check("arst_score", {16'd0, m_score}, 32'd0);
        check("arst_idx", {21'd0, m_col, m_row}, 32'd0);
        check("arst_strobes", {28'd0, m_nextcol, m_nrt, m_nrb, m_go}, 32'd0);
        check("arst_done_err", {30'd0, m_done, m_err}, 32'd0);
        @(negedge clk) rst = 1'b0;
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            rowtopready = 1'b1;
            rowbotready = 1'b1;
            colready    = 1'b1;
            alu_done    = i[0];
            step();
            if (m_go || m_nextcol || m_nrt || m_busy) cnt++;
        end
        clear_inputs();
        check("arst_quiet", cnt, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/compare_sequencer.md
COMPARE_SEQUENCER -- requirements
Module: compare_sequencer

Interface
REQ-001 Parameter NCOLS, default 24, number of column slices per bitmap.
REQ-002 Parameter NROWPAIRS, default 32, number of top/bottom row-slice pairs per bitmap.
REQ-003 Parameter TIMEOUT, default 255, maximum cycles spent waiting for any ready or alu_done; range 1..255.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 start  input  1  one-cycle pulse: bitmap register has just been loaded; begin a comparison pass.
REQ-007 nextcol  output  1  one-cycle request for the next column slice.
REQ-008 nextrowtop  output  1  one-cycle request for the next top row slice.
REQ-009 nextrowbot  output  1  one-cycle request for the next bottom row slice.
REQ-010 colready  input  1  column slice valid; pulse of one or more cycles.
REQ-011 rowtopready  input  1  top row slice valid.
REQ-012 rowbotready  input  1  bottom row slice valid.
REQ-013 alu_go  output  1  one-cycle pulse: ALU operands valid, start compare.
REQ-014 alu_sel  output  1  0 = column compare, 1 = row-pair compare; valid while alu_go high.
REQ-015 alu_done  input  1  ALU result valid pulse.
REQ-016 alu_score  input  8  unsigned match score, valid with alu_done.
REQ-017 busy  output  1  high in any state except IDLE and DONE.
REQ-018 done  output  1  high while in DONE.
REQ-019 error  output  1  timeout occurred on the last pass; valid while done.
REQ-020 score  output  16  accumulated match score of the current/last pass.
REQ-021 col_idx  output  5  number of column compares completed in this pass.
REQ-022 row_idx  output  6  number of row-pair compares completed in this pass.

Function
REQ-023 FSM states: IDLE, COL_REQ, COL_WAIT, COL_ALU, ROW_REQ, ROW_WAIT, ROW_ALU, DONE.
REQ-024 IDLE or DONE + start -> COL_REQ; score, col_idx, row_idx, error, timeout counter cleared in that transition cycle.
REQ-025 start in any busy state SHALL be ignored.
REQ-026 COL_REQ: nextcol=1 for exactly that cycle; -> COL_WAIT next cycle.
REQ-027 COL_WAIT: colready=1 -> COL_ALU with alu_go=1, alu_sel=0 issued in the COL_WAIT->COL_ALU transition cycle (registered, visible first cycle of COL_ALU).
REQ-028 COL_ALU: alu_done=1 -> score += alu_score, col_idx += 1; if new col_idx == NCOLS -> ROW_REQ, else -> COL_REQ.
REQ-029 ROW_REQ: nextrowtop=1 and nextrowbot=1 together for exactly that cycle; sticky flags top_got/bot_got cleared; -> ROW_WAIT.
REQ-030 ROW_WAIT: rowtopready sets top_got, rowbotready sets bot_got, independently, in any cycle order; when both set (including both same cycle) -> ROW_ALU with alu_go=1, alu_sel=1.
REQ-031 ROW_ALU: alu_done=1 -> score += alu_score, row_idx += 1; if new row_idx == NROWPAIRS -> DONE, else -> ROW_REQ.
REQ-032 Score addition SHALL saturate at 16'hFFFF; no wrap.
REQ-033 Ready inputs and alu_done outside their waiting state SHALL be ignored.
REQ-034 Timeout counter (8-bit) clears on entry to COL_WAIT, COL_ALU, ROW_WAIT, ROW_ALU; increments each cycle in those states; reaching TIMEOUT without the awaited event -> DONE with error=1; partial score retained.
REQ-035 DONE: done=1, busy=0; held until start (new pass) or rst.
REQ-036 Minimum cycles per compare: 3 (REQ, WAIT with ready same cycle, ALU with alu_done same cycle); minimum pass = 3*(NCOLS+NROWPAIRS) = 168 cycles plus 1 DONE entry.
REQ-037 Request and alu_go outputs SHALL be registered and never high for two consecutive cycles.

Reset
REQ-038 rst=1 asynchronously forces IDLE; nextcol, nextrowtop, nextrowbot, alu_go, alu_sel, busy, done, error = 0; score = 0; col_idx = 0; row_idx = 0; sticky flags and timeout counter = 0.
REQ-039 rst asserted mid-pass SHALL abort the pass; no further requests issued until a new start after rst release.

Verification
REQ-040 Full pass, immediate responder (ready one cycle after request, alu_done one cycle after alu_go, alu_score=1) -> 24 nextcol pulses, 32 paired row pulses, done=1, score=56, error=0, col_idx=24, row_idx=32.
REQ-041 Row readies skewed: rowtopready 1 cycle and rowbotready 5 cycles after request -> exactly one alu_go per pair, issued after rowbotready; same for reversed order and simultaneous arrival.
REQ-042 colready never returned on column 3 -> after 255 wait cycles done=1, error=1, col_idx=3, no further nextcol.
REQ-043 alu_score=255 on all 56 compares -> score=14280; then force alu_score=255 with NCOLS=NROWPAIRS large enough to exceed 65535 -> score holds 16'hFFFF.
REQ-044 start pulsed during COL_WAIT and during ROW_ALU -> ignored, pass completes with unchanged counts; start in DONE -> restart with score cleared.
REQ-045 rst asserted in ROW_WAIT asynchronously (between clock edges) -> all outputs 0 immediately; subsequent readies produce no alu_go.
